// File: rtl/byte_word_packer_pkg.sv
// byte_word_packer_pkg: shared byte width, slot mapping and clog2 helper for the byte-to-word packer
package pack_pkg;
  localparam int BYTE_W = 8;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int slot_idx(input int cnt, input bit msb_first, input int bpw);
    return msb_first ? bpw - 1 - cnt : cnt;
  endfunction
endpackage

// File: rtl/byte_word_packer_if.sv
// byte_word_packer_if: byte input strobe, word valid/ready output and status flags of the packer
interface byte_word_packer_if
  import pack_pkg::*;
#(parameter int BYTES_PER_WORD = 4) ();
  localparam int W = BYTE_W * BYTES_PER_WORD;
  localparam int C = clog2(BYTES_PER_WORD);
  logic [BYTE_W-1:0] in_data;
  logic in_valid;
  logic [W-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic [C-1:0] byte_cnt;
  logic overflow;
  logic timeout;
  modport master (output in_data, in_valid, out_ready, input out_data, out_valid, byte_cnt, overflow, timeout);
  modport slave (input in_data, in_valid, out_ready, output out_data, out_valid, byte_cnt, overflow, timeout);
endinterface

// File: rtl/byte_word_packer_idle_timer.sv
// pack_idle_timer: counts idle cycles while started, restarts on clear, pulses expired on the CYCLES-th idle cycle
module pack_idle_timer
  import pack_pkg::*;
#(parameter int CYCLES = 50000) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expired
);
  localparam int N = clog2(CYCLES);
  logic [N-1:0] r_t;
  assign expired = start && !clear && r_t == N'(CYCLES - 1);
  always_ff @(posedge clk)
    if (rst || clear || expired || !start) r_t <= '0;
    else r_t <= r_t + N'(1);
endmodule

// File: rtl/byte_word_packer.sv
// byte_word_packer: packs bytes into words with a valid/ready output register; PACK_TIMEOUT_EN adds partial-word timeout
module byte_word_packer
  import pack_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter bit MSB_FIRST = 1,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic clk,
  input logic rst,
  byte_word_packer_if.slave bus
);
  localparam int W = BYTE_W * BYTES_PER_WORD;
  localparam int C = clog2(BYTES_PER_WORD);
  logic [W-1:0] r_asm, r_out, w_asm;
  logic [C-1:0] r_cnt;
  logic r_valid, r_ovf, r_tmo, w_last, w_load, w_exp;
  always_comb begin
    w_asm = r_asm;
    w_asm[BYTE_W*slot_idx(int'(r_cnt), MSB_FIRST, BYTES_PER_WORD) +: BYTE_W] = bus.in_data;
  end
  assign w_last = bus.in_valid && r_cnt == C'(BYTES_PER_WORD - 1);
  // a completed word is taken only if the output register is empty or draining this cycle
  assign w_load = w_last && (!r_valid || bus.out_ready);
`ifdef PACK_TIMEOUT_EN
  pack_idle_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .start(r_cnt != '0),
    .clear(bus.in_valid),
    .expired(w_exp)
  );
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign w_exp = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      r_asm <= '0;
      r_out <= '0;
      r_cnt <= '0;
      r_valid <= 1'b0;
      r_ovf <= 1'b0;
      r_tmo <= 1'b0;
    end else begin
      r_cnt <= bus.in_valid ? (w_last ? '0 : r_cnt + C'(1)) : (w_exp ? '0 : r_cnt);
      if (bus.in_valid) r_asm <= w_asm;
      if (w_load) r_out <= w_asm;
      r_valid <= w_load || (r_valid && !bus.out_ready);
      r_ovf <= r_ovf || (w_last && r_valid && !bus.out_ready);
      r_tmo <= w_exp;
    end
  assign bus.out_data = r_out;
  assign bus.out_valid = r_valid;
  assign bus.byte_cnt = r_cnt;
  assign bus.overflow = r_ovf;
  assign bus.timeout = r_tmo;
endmodule

// File: tb/tb_byte_word_packer.sv
// tb_byte_word_packer: table-driven and hand-written sequences with a word scoreboard for two packer configurations
module tb_byte_word_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  byte_word_packer_if #(.BYTES_PER_WORD(4)) b4();
  byte_word_packer_if #(.BYTES_PER_WORD(2)) b2();
  byte_word_packer #(.BYTES_PER_WORD(4), .MSB_FIRST(1), .TIMEOUT_CYCLES(10)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  byte_word_packer #(.BYTES_PER_WORD(2), .MSB_FIRST(0), .TIMEOUT_CYCLES(10)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
  typedef struct {logic [7:0] b0, b1, b2, b3; logic [31:0] w;} vec4_t;
  typedef struct {logic [7:0] b0, b1; logic [15:0] w;} vec2_t;
  int tests = 0;
  int fails = 0;
  logic [31:0] q4[$];
  logic [15:0] q2[$];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put4(input logic [7:0] d);
    b4.in_data = d;
    b4.in_valid = 1'b1;
    tick();
    b4.in_valid = 1'b0;
  endtask
  task automatic put2(input logic [7:0] d);
    b2.in_data = d;
    b2.in_valid = 1'b1;
    tick();
    b2.in_valid = 1'b0;
  endtask
  always @(negedge clk)
    if (!rst && b4.out_valid && b4.out_ready) begin
      if (q4.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL w4_extra: got word %h expected no word", b4.out_data);
      end else chk("w4_word", b4.out_data, q4.pop_front());
    end
  always @(negedge clk)
    if (!rst && b2.out_valid && b2.out_ready) begin
      if (q2.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL w2_extra: got word %h expected no word", b2.out_data);
      end else chk("w2_word", 32'(b2.out_data), 32'(q2.pop_front()));
    end
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end
  initial begin
    vec4_t v4[4];
    vec2_t v2[3];
    v4[0] = '{8'h00, 8'h00, 8'h00, 8'h01, 32'h00000001};
    v4[1] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 32'hFF00FF00};
    v4[2] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hDEADBEEF};
    v4[3] = '{8'h80, 8'h7F, 8'h01, 8'hFE, 32'h807F01FE};
    v2[0] = '{8'hAA, 8'hBB, 16'hBBAA};
    v2[1] = '{8'hCC, 8'hDD, 16'hDDCC};
    v2[2] = '{8'h01, 8'h80, 16'h8001};
    b4.in_data = '0; b4.in_valid = 1'b0; b4.out_ready = 1'b0;
    b2.in_data = '0; b2.in_valid = 1'b0; b2.out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_data", b4.out_data, 32'h0);
    chk("rst_valid", 32'(b4.out_valid), 32'h0);
    chk("rst_cnt", 32'(b4.byte_cnt), 32'h0);
    chk("rst_ovf", 32'(b4.overflow), 32'h0);
    chk("rst_tmo", 32'(b4.timeout), 32'h0);
    b4.out_ready = 1'b1;
    q4.push_back(32'h12345678);
    put4(8'h12);
    chk("cnt_after_1", 32'(b4.byte_cnt), 32'h1);
    put4(8'h34); put4(8'h56); put4(8'h78);
    chk("basic_valid", 32'(b4.out_valid), 32'h1);
    chk("basic_data", b4.out_data, 32'h12345678);
    chk("basic_cnt_wrap", 32'(b4.byte_cnt), 32'h0);
    tick();
    chk("basic_valid_drop", 32'(b4.out_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      q4.push_back(v4[i].w);
      put4(v4[i].b0); put4(v4[i].b1); put4(v4[i].b2); put4(v4[i].b3);
    end
    repeat (2) tick();
    chk("tbl4_drained", 32'(q4.size()), 32'h0);
    b2.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q2.push_back(v2[i].w);
      put2(v2[i].b0);
      chk("cnt2_half", 32'(b2.byte_cnt), 32'h1);
      put2(v2[i].b1);
    end
    repeat (2) tick();
    chk("tbl2_drained", 32'(q2.size()), 32'h0);
    chk("tbl2_cnt", 32'(b2.byte_cnt), 32'h0);
    b4.out_ready = 1'b0;
    q4.push_back(32'h01020304);
    for (int i = 1; i <= 8; i++) put4(8'(i));
    chk("ovf_hold_data", b4.out_data, 32'h01020304);
    chk("ovf_hold_valid", 32'(b4.out_valid), 32'h1);
    chk("ovf_set", 32'(b4.overflow), 32'h1);
    b4.out_ready = 1'b1;
    tick();
    chk("ovf_drain_valid", 32'(b4.out_valid), 32'h0);
    chk("ovf_sticky", 32'(b4.overflow), 32'h1);
    chk("ovf_q", 32'(q4.size()), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ovf_cleared_by_rst", 32'(b4.overflow), 32'h0);
    b4.out_ready = 1'b0;
    q4.push_back(32'h11223344);
    put4(8'h11); put4(8'h22); put4(8'h33); put4(8'h44);
    put4(8'hA1); put4(8'hB2); put4(8'hC3);
    chk("dl_hold", b4.out_data, 32'h11223344);
    q4.push_back(32'hA1B2C3D4);
    b4.out_ready = 1'b1;
    put4(8'hD4);
    chk("dl_data", b4.out_data, 32'hA1B2C3D4);
    chk("dl_valid", 32'(b4.out_valid), 32'h1);
    chk("dl_ovf", 32'(b4.overflow), 32'h0);
    tick();
    chk("dl_q", 32'(q4.size()), 32'h0);
    put4(8'h01); put4(8'h02);
    repeat (9) tick();
    chk("idle9_tmo", 32'(b4.timeout), 32'h0);
    chk("idle9_cnt", 32'(b4.byte_cnt), 32'h2);
    tick();
`ifdef PACK_TIMEOUT_EN
    chk("tmo_pulse", 32'(b4.timeout), 32'h1);
    chk("tmo_cnt", 32'(b4.byte_cnt), 32'h0);
    tick();
    chk("tmo_one_cycle", 32'(b4.timeout), 32'h0);
    q4.push_back(32'hDEADBEEF);
    put4(8'hDE); put4(8'hAD); put4(8'hBE); put4(8'hEF);
    chk("tmo_word", b4.out_data, 32'hDEADBEEF);
`else
    chk("no_tmo", 32'(b4.timeout), 32'h0);
    chk("partial_kept", 32'(b4.byte_cnt), 32'h2);
    q4.push_back(32'h01020304);
    put4(8'h03); put4(8'h04);
    chk("partial_word", b4.out_data, 32'h01020304);
`endif
    tick();
    b4.out_ready = 1'b0;
    put4(8'hC0); put4(8'hFF); put4(8'hEE); put4(8'h11);
    put4(8'h55); put4(8'h66);
    chk("pre_rst_valid", 32'(b4.out_valid), 32'h1);
    rst = 1'b1;
    tick();
    q4.delete();
    chk("mid_rst_data", b4.out_data, 32'h0);
    chk("mid_rst_valid", 32'(b4.out_valid), 32'h0);
    chk("mid_rst_cnt", 32'(b4.byte_cnt), 32'h0);
    chk("mid_rst_ovf", 32'(b4.overflow), 32'h0);
    rst = 1'b0;
    b4.out_ready = 1'b1;
    q4.push_back(32'h0A0B0C0D);
    put4(8'h0A); put4(8'h0B); put4(8'h0C); put4(8'h0D);
    chk("post_rst_data", b4.out_data, 32'h0A0B0C0D);
    repeat (3) tick();
    chk("post_rst_valid", 32'(b4.out_valid), 32'h0);
    chk("final_q4", 32'(q4.size()), 32'h0);
    chk("final_q2", 32'(q2.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
